sc_exception_sequencer: RTL and testbench

Sequencer for exception and interrupt entry and return in the single-cycle MIPS core. It prioritises synchronous faults over latched external interrupts and redirects fetch to the handler vector. It saves EPC and Cause, masks nesting while a handler runs, and restores state on `eret`. A fault taken inside a handler (double fault) halts the core until reset.

---
 rtl/sc_exception_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_sc_exception_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_exception_sequencer.sv
// Exception/interrupt sequencer for the single-cycle MIPS core: prioritises faults over
// latched IRQs, redirects fetch to handler vectors, saves EPC/Cause and returns on eret.
module sc_exception_sequencer #(
    parameter int unsigned NUM_IRQ                = 4,
    parameter logic [31:0] IRQ_VECTOR_BASE        = 32'h0000_0200,
    parameter logic [31:0] UNDEFINED_HANDLER_ADDR = 32'h0000_0180,
    parameter logic [31:0] OVERFLOW_HANDLER_ADDR  = 32'h0000_01C0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               undefined_instr,
    input  logic               overflow,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [31:0]        pc_current,
    input  logic               cfg_we,
    input  logic [NUM_IRQ:0]   cfg_wdata,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               kill,
    output logic [31:0]        epc,
    output logic [4:0]         cause,
    output logic [NUM_IRQ:0]   status,
    output logic [NUM_IRQ-1:0] pending,
    output logic               in_handler,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HANDLER = 2'd1,
        ST_HALT    = 2'd2
    } state_e;

    localparam logic [4:0] CAUSE_NONE      = 5'd0;
    localparam logic [4:0] CAUSE_UNDEFINED = 5'd1;
    localparam logic [4:0] CAUSE_OVERFLOW  = 5'd2;

    state_e             state_q, state_d;
    logic [31:0]        epc_q, epc_d;
    logic [4:0]         cause_q, cause_d;
    logic [NUM_IRQ-1:0] im_q, im_d;
    logic               ie_q, ie_d;
    logic               prev_ie_q, prev_ie_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;

    logic               cand_valid;
    logic [4:0]         cand_code;
    logic [31:0]        cand_vec;
    logic [NUM_IRQ-1:0] cand_irq_hit;
    logic               fault;
    logic [4:0]         fault_code;

    assign fault      = undefined_instr | overflow;
    assign fault_code = undefined_instr ? CAUSE_UNDEFINED : CAUSE_OVERFLOW;

    // Candidate selection: faults first, then the lowest-numbered enabled pending IRQ.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        cand_valid   = 1'b0;
        cand_code    = CAUSE_NONE;
        cand_vec     = '0;
        cand_irq_hit = '0;
        if (undefined_instr) begin
            cand_valid = 1'b1;
            cand_code  = CAUSE_UNDEFINED;
            cand_vec   = UNDEFINED_HANDLER_ADDR;
        end else if (overflow) begin
            cand_valid = 1'b1;
            cand_code  = CAUSE_OVERFLOW;
            cand_vec   = OVERFLOW_HANDLER_ADDR;
        end else begin
            for (int i = 0; i < int'(NUM_IRQ); i++) begin
                if (!cand_valid && pending_q[i] && im_q[i] && ie_q) begin
                    cand_valid      = 1'b1;
                    cand_code       = 5'(16 + i);
                    cand_vec        = IRQ_VECTOR_BASE + (32'(i) << 4);
                    cand_irq_hit[i] = 1'b1;
                end
            end
        end
    end

    // State register and all architectural flops.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            epc_q      <= '0;
            cause_q    <= CAUSE_NONE;
            im_q       <= '1;
            ie_q       <= 1'b0;
            prev_ie_q  <= 1'b0;
            pending_q  <= '0;
            irq_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            im_q       <= im_d;
            ie_q       <= ie_d;
            prev_ie_q  <= prev_ie_d;
            pending_q  <= pending_d;
            irq_prev_q <= irq_prev_d;
        end
    end

    // Next-state and register update logic.
    always_comb begin
        state_d    = state_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        im_d       = im_q;
        ie_d       = ie_q;
        prev_ie_d  = prev_ie_q;
        irq_prev_d = irq;
        pending_d  = pending_q | (irq & ~irq_prev_q);

        // Status writes come first so entry and eret below can override IE.
        if (enable && state_q != ST_HALT && cfg_we) begin
            im_d = cfg_wdata[NUM_IRQ:1];
            ie_d = cfg_wdata[0];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable && cand_valid) begin
                    epc_d     = pc_current;
                    cause_d   = cand_code;
                    prev_ie_d = ie_q;
                    ie_d      = 1'b0;
                    state_d   = ST_HANDLER;
                    pending_d = pending_d & ~cand_irq_hit;
                end
            end
            ST_HANDLER: begin
                if (enable) begin
                    if (fault) begin
                        cause_d = fault_code;
                        state_d = ST_HALT;
                    end else if (eret) begin
                        ie_d    = prev_ie_q;
                        cause_d = CAUSE_NONE;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Combinational fetch redirect and writeback kill.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        kill        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && cand_valid) begin
                    redirect    = 1'b1;
                    redirect_pc = cand_vec;
                    kill        = 1'b1;
                end
            end
            ST_HANDLER: begin
                if (enable && fault) begin
                    redirect    = 1'b1;
                    redirect_pc = pc_current;
                    kill        = 1'b1;
                end else if (enable && eret) begin
                    redirect    = 1'b1;
                    redirect_pc = epc_q;
                end
            end
            ST_HALT: begin
                redirect    = 1'b1;
                redirect_pc = pc_current;
                kill        = 1'b1;
            end
            default: begin
                redirect = 1'b0;
            end
        endcase
    end

    assign epc        = epc_q;
    assign cause      = cause_q;
    assign status     = {im_q, ie_q};
    assign pending    = pending_q;
    assign in_handler = (state_q == ST_HANDLER);
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_sc_exception_sequencer.sv
// Directed bench for sc_exception_sequencer: entry, priority, eret, IRQ masking,
// enable freeze, double-fault halt and reset recovery.
module tb_sc_exception_sequencer;

    localparam int unsigned NUM_IRQ  = 4;
    localparam logic [31:0] IRQ_BASE = 32'h0000_0200;
    localparam logic [31:0] UND_VEC  = 32'h0000_0180;
    localparam logic [31:0] OVF_VEC  = 32'h0000_01C0;

    logic               clk;
    logic               reset_n;
    logic               enable;
    logic               undefined_instr;
    logic               overflow;
    logic               eret;
    logic [NUM_IRQ-1:0] irq;
    logic [31:0]        pc_current;
    logic               cfg_we;
    logic [NUM_IRQ:0]   cfg_wdata;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               kill;
    logic [31:0]        epc;
    logic [4:0]         cause;
    logic [NUM_IRQ:0]   status;
    logic [NUM_IRQ-1:0] pending;
    logic               in_handler;
    logic               halted;

    int n_cmp = 0;
    int n_err = 0;

    sc_exception_sequencer #(
        .NUM_IRQ                (NUM_IRQ),
        .IRQ_VECTOR_BASE        (IRQ_BASE),
        .UNDEFINED_HANDLER_ADDR (UND_VEC),
        .OVERFLOW_HANDLER_ADDR  (OVF_VEC)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .undefined_instr (undefined_instr),
        .overflow        (overflow),
        .eret            (eret),
        .irq             (irq),
        .pc_current      (pc_current),
        .cfg_we          (cfg_we),
        .cfg_wdata       (cfg_wdata),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .kill            (kill),
        .epc             (epc),
        .cause           (cause),
        .status          (status),
        .pending         (pending),
        .in_handler      (in_handler),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_handler"}, 32'(in_handler), 32'd0);
        check({tag, "_halted"},     32'(halted),     32'd0);
        check({tag, "_epc"},        epc,             32'd0);
        check({tag, "_cause"},      32'(cause),      32'd0);
        check({tag, "_status"},     32'(status),     32'h1E);
        check({tag, "_pending"},    32'(pending),    32'd0);
        check({tag, "_redirect"},   32'(redirect),   32'd0);
        check({tag, "_redir_pc"},   redirect_pc,     32'd0);
        check({tag, "_kill"},       32'(kill),       32'd0);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; undefined_instr = 1'b0; overflow = 1'b0;
        eret = 1'b0; irq = '0; pc_current = 32'h0; cfg_we = 1'b0; cfg_wdata = '0;
        tick(); tick();
        check_reset_state("rst");
        reset_n = 1'b1;
        tick();

        // Enable interrupts globally, IM stays all ones.
        cfg_we = 1'b1; cfg_wdata = 5'b1_1111;
        tick();
        cfg_we = 1'b0;
        check("cfg_status", 32'(status), 32'h1F);

        // Undefined instruction at 0x40.
        undefined_instr = 1'b1; pc_current = 32'h40;
        settle();
        check("und_redirect", 32'(redirect), 32'd1);
        check("und_redir_pc", redirect_pc, UND_VEC);
        check("und_kill", 32'(kill), 32'd1);
        tick();
        undefined_instr = 1'b0; pc_current = 32'h180;
        check("und_epc", epc, 32'h40);
        check("und_cause", 32'(cause), 32'd1);
        check("und_in_handler", 32'(in_handler), 32'd1);
        check("und_status", 32'(status), 32'h1E);

        // eret in the first handler cycle.
        eret = 1'b1;
        settle();
        check("eret1_redirect", 32'(redirect), 32'd1);
        check("eret1_redir_pc", redirect_pc, 32'h40);
        check("eret1_kill", 32'(kill), 32'd0);
        tick();
        eret = 1'b0; pc_current = 32'h44;
        check("eret1_in_handler", 32'(in_handler), 32'd0);
        check("eret1_cause", 32'(cause), 32'd0);
        check("eret1_status", 32'(status), 32'h1F);

        // IRQ 2 edge, then overflow in the same cycle pending[2] is visible.
        irq = 4'b0100;
        settle();
        check("irq2_edge_no_redirect", 32'(redirect), 32'd0);
        tick();
        check("irq2_pending", 32'(pending), 32'b0100);
        overflow = 1'b1; pc_current = 32'h80;
        settle();
        check("ovf_redir_pc", redirect_pc, OVF_VEC);
        tick();
        overflow = 1'b0; pc_current = 32'h1C0;
        check("ovf_cause", 32'(cause), 32'd2);
        check("ovf_epc", epc, 32'h80);
        check("ovf_pending_kept", 32'(pending), 32'b0100);
        eret = 1'b1;
        settle();
        check("eret2_redir_pc", redirect_pc, 32'h80);
        tick();
        eret = 1'b0; pc_current = 32'h80;
        settle();
        check("irq2_redir_pc", redirect_pc, 32'h220);
        check("irq2_kill", 32'(kill), 32'd1);
        tick();
        pc_current = 32'h220;
        check("irq2_cause", 32'(cause), 32'd18);
        check("irq2_epc", epc, 32'h80);
        check("irq2_pending_clr", 32'(pending), 32'd0);
        eret = 1'b1;
        tick();
        eret = 1'b0; irq = '0; pc_current = 32'h80;

        // IM = 1001: IRQ 0 and 3 rise together.
        cfg_we = 1'b1; cfg_wdata = 5'b1001_1;
        tick();
        cfg_we = 1'b0;
        irq = 4'b1001;
        tick();
        check("irq03_pending", 32'(pending), 32'b1001);
        settle();
        check("irq0_redir_pc", redirect_pc, 32'h200);
        tick();
        check("irq0_cause", 32'(cause), 32'd16);
        check("irq0_pending", 32'(pending), 32'b1000);
        pc_current = 32'h200; eret = 1'b1;
        tick();
        eret = 1'b0; pc_current = 32'h80;
        settle();
        check("irq3_redir_pc", redirect_pc, 32'h230);
        tick();
        check("irq3_cause", 32'(cause), 32'd19);
        check("irq3_pending", 32'(pending), 32'd0);
        pc_current = 32'h230; eret = 1'b1;
        tick();
        eret = 1'b0; pc_current = 32'h80; irq = '0;

        // Mask IRQ 3 (IM = 0001): its edge pends but is never taken.
        cfg_we = 1'b1; cfg_wdata = 5'b0001_1;
        tick();
        cfg_we = 1'b0;
        irq = 4'b1000;
        tick();
        tick();
        settle();
        check("masked_redirect", 32'(redirect), 32'd0);
        tick();
        check("masked_pending", 32'(pending), 32'b1000);
        check("masked_in_handler", 32'(in_handler), 32'd0);

        // Handler entered from 0x100, eret restores IE.
        undefined_instr = 1'b1; pc_current = 32'h100;
        tick();
        undefined_instr = 1'b0; pc_current = 32'h180;
        check("h100_status", 32'(status), 32'b0001_0);
        eret = 1'b1;
        settle();
        check("h100_redir_pc", redirect_pc, 32'h100);
        tick();
        eret = 1'b0; pc_current = 32'h100;
        check("h100_status_ret", 32'(status), 32'b0001_1);
        check("h100_cause", 32'(cause), 32'd0);
        check("h100_in_handler", 32'(in_handler), 32'd0);

        // enable=0 freezes: fault ignored, IRQ 0 edge still captured.
        enable = 1'b0; undefined_instr = 1'b1; irq = 4'b1001; pc_current = 32'h300;
        settle();
        check("frz_redirect", 32'(redirect), 32'd0);
        check("frz_kill", 32'(kill), 32'd0);
        tick();
        check("frz_in_handler", 32'(in_handler), 32'd0);
        check("frz_pending", 32'(pending), 32'b1001);
        check("frz_cause", 32'(cause), 32'd0);
        enable = 1'b1;
        settle();
        check("thaw_redir_pc", redirect_pc, UND_VEC);
        tick();
        undefined_instr = 1'b0; pc_current = 32'h180;
        check("thaw_cause", 32'(cause), 32'd1);
        check("thaw_pending", 32'(pending), 32'b1001);
        eret = 1'b1;
        tick();
        eret = 1'b0; pc_current = 32'h304;
        settle();
        check("irq0b_redir_pc", redirect_pc, 32'h200);
        tick();
        check("irq0b_cause", 32'(cause), 32'd16);

        // Double fault inside the handler halts the core.
        overflow = 1'b1; pc_current = 32'h2000;
        settle();
        check("dbl_redirect", 32'(redirect), 32'd1);
        check("dbl_redir_pc", redirect_pc, 32'h2000);
        check("dbl_kill", 32'(kill), 32'd1);
        tick();
        overflow = 1'b0;
        check("dbl_halted", 32'(halted), 32'd1);
        check("dbl_cause", 32'(cause), 32'd2);
        check("dbl_epc", epc, 32'h304);
        enable = 1'b0; pc_current = 32'h2004;
        settle();
        check("halt_redirect", 32'(redirect), 32'd1);
        check("halt_redir_pc", redirect_pc, 32'h2004);
        check("halt_kill", 32'(kill), 32'd1);
        enable = 1'b1; eret = 1'b1; cfg_we = 1'b1; cfg_wdata = 5'b1111_1;
        tick();
        eret = 1'b0; cfg_we = 1'b0;
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_no_cfg", 32'(status), 32'b0001_0);

        // Reset out of HALT.
        reset_n = 1'b0; irq = '0; pc_current = 32'h0;
        tick();
        check_reset_state("rst_halt");
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
